// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_pkg
//  Description : Shared constants for the registered N-way datapath mux.
//  Revision    : 1.0  initial release
// ============================================================================
package mux_pkg;

    localparam logic MODE_DIRECT   = 1'b0;
    localparam logic MODE_SCAN     = 1'b1;
    localparam int   DEFAULT_WIDTH = 32;

endpackage : mux_pkg
`default_nettype wire

// File: rtl/mux_scan_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : mux_scan_ctr
//  Description : Wrapping 0..N_IN-1 index counter for scan-mode selection.
//  Revision    : 1.0  initial release
// ============================================================================
module mux_scan_ctr
    import mux_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [SEL_W-1:0] count
);

    localparam logic [SEL_W-1:0] c_last = SEL_W'(N_IN - 1);

    logic [SEL_W-1:0] r_count;

    // Clear wins over increment, so a capture coinciding with clear lands on 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= (r_count == c_last) ? '0 : r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule : mux_scan_ctr
`default_nettype wire

// File: rtl/mux_n_reg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_n_reg
//  Description : Registered N-way mux with valid/ready output stage, scan mode
//                and sticky out-of-range select flag.
//  Revision    : 1.0  initial release
// ============================================================================
module mux_n_reg
    import mux_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int N_IN        = 3,
    parameter int SEL_W       = 3,
    parameter int DEFAULT_IDX = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_IN*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]      selector,
    input  logic                  mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  out_ready,
    input  logic                  scan_clr,
    input  logic                  err_clr,
    output logic [WIDTH-1:0]      data_out,
    output logic                  out_valid,
    output logic [SEL_W-1:0]      out_sel,
    output logic                  sel_err
);

    localparam int               c_n_slots     = 1 << SEL_W;
    localparam logic [SEL_W:0]   c_n_in        = (SEL_W + 1)'(N_IN);
    localparam logic [SEL_W-1:0] c_default_idx = SEL_W'(DEFAULT_IDX);

    logic [WIDTH-1:0] w_slot [c_n_slots];
    logic [SEL_W-1:0] w_count;
    logic [SEL_W-1:0] w_idx;
    logic             w_bad;
    logic             w_capture;
    logic             w_scan_inc;

    logic [WIDTH-1:0] r_data;
    logic [SEL_W-1:0] r_sel;
    logic             r_valid;
    logic             r_err;

    // Pad the slot array to the full selector range so indexing is always legal.
    for (genvar k = 0; k < c_n_slots; k++) begin : g_slot
        if (k < N_IN) begin : g_in
            assign w_slot[k] = data_in[k*WIDTH +: WIDTH];
        end else begin : g_pad
            assign w_slot[k] = '0;
        end
    end

    assign in_ready   = !r_valid || out_ready;
    assign w_capture  = in_valid && in_ready;
    assign w_scan_inc = w_capture && (mode == MODE_SCAN);

    always_comb begin
        w_idx = selector;
        w_bad = 1'b0;
        if (mode == MODE_SCAN) begin
            w_idx = w_count;
        end else if ({1'b0, selector} >= c_n_in) begin
            w_idx = c_default_idx;
            w_bad = 1'b1;
        end
    end

    mux_scan_ctr #(
        .N_IN  (N_IN),
        .SEL_W (SEL_W)
    ) u_scan_ctr (
        .clk   (clk),
        .reset (reset),
        .inc   (w_scan_inc),
        .clr   (scan_clr),
        .count (w_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data  <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_data  <= w_slot[w_idx];
            r_sel   <= w_idx;
            r_valid <= 1'b1;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_capture && w_bad) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign data_out  = r_data;
    assign out_valid = r_valid;
    assign out_sel   = r_sel;
    assign sel_err   = r_err;

endmodule : mux_n_reg
`default_nettype wire

// File: tb/tb_mux_n_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_n_reg
//  Description : Self-checking bench: 32-bit/3-input vector table plus an
//                8-bit/8-input scoreboard sweep with random backpressure.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mux_n_reg;

    localparam logic [31:0] A = 32'hAAAA0000;
    localparam logic [31:0] B = 32'hBBBB0001;
    localparam logic [31:0] C = 32'hCCCC0002;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: WIDTH=32, N_IN=3
    logic [95:0] data_a;
    logic [2:0]  sel_a;
    logic        mode_a, iv_a, ordy_a, sclr_a, eclr_a;
    logic        ir_a, ov_a, err_a;
    logic [31:0] dout_a;
    logic [2:0]  osel_a;

    mux_n_reg #(.WIDTH(32), .N_IN(3), .SEL_W(3), .DEFAULT_IDX(0)) u_dut_a (
        .clk(clk), .reset(rst), .data_in(data_a), .selector(sel_a), .mode(mode_a),
        .in_valid(iv_a), .in_ready(ir_a), .out_ready(ordy_a), .scan_clr(sclr_a),
        .err_clr(eclr_a), .data_out(dout_a), .out_valid(ov_a), .out_sel(osel_a),
        .sel_err(err_a)
    );

    // Instance B: WIDTH=8, N_IN=8
    logic [63:0] data_b;
    logic [2:0]  sel_b;
    logic        iv_b, ordy_b;
    logic        ir_b, ov_b, err_b;
    logic [7:0]  dout_b;
    logic [2:0]  osel_b;

    mux_n_reg #(.WIDTH(8), .N_IN(8), .SEL_W(3), .DEFAULT_IDX(0)) u_dut_b (
        .clk(clk), .reset(rst), .data_in(data_b), .selector(sel_b), .mode(1'b0),
        .in_valid(iv_b), .in_ready(ir_b), .out_ready(ordy_b), .scan_clr(1'b0),
        .err_clr(1'b0), .data_out(dout_b), .out_valid(ov_b), .out_sel(osel_b),
        .sel_err(err_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        iv;
        logic [2:0]  sel;
        logic        mode;
        logic        ordy;
        logic        eclr;
        logic        sclr;
        logic        er;
        logic        ev;
        logic [31:0] ed;
        logic [2:0]  es;
        logic        ee;
    } vec_t;

    function automatic vec_t mk(logic iv, logic [2:0] sel, logic mode, logic ordy,
                                logic eclr, logic sclr, logic er, logic ev,
                                logic [31:0] ed, logic [2:0] es, logic ee);
        vec_t v;
        v = '{iv, sel, mode, ordy, eclr, sclr, er, ev, ed, es, ee};
        return v;
    endfunction

    // Drive one vector, check combinational in_ready, clock, check registered outputs.
    task automatic apply_vec(input vec_t v, input string tag);
        iv_a   = v.iv;
        sel_a  = v.sel;
        mode_a = v.mode;
        ordy_a = v.ordy;
        eclr_a = v.eclr;
        sclr_a = v.sclr;
        #1;
        check({tag, ".in_ready"}, 64'(ir_a), 64'(v.er));
        @(posedge clk);
        #1;
        check({tag, ".out_valid"}, 64'(ov_a), 64'(v.ev));
        check({tag, ".data_out"},  64'(dout_a), 64'(v.ed));
        check({tag, ".out_sel"},   64'(osel_a), 64'(v.es));
        check({tag, ".sel_err"},   64'(err_a), 64'(v.ee));
    endtask

    function automatic logic [7:0] byte_b(int k);
        return 8'(k * 37 + 5);
    endfunction

    typedef struct packed {
        logic [7:0] d;
        logic [2:0] s;
    } sb_t;

    vec_t tbl [22];
    vec_t rst_seq [3];

    initial begin
        sb_t q[$];
        int  next_sel;
        int  cyc;
        logic rdy_m;

        data_a = {C, B, A};
        for (int k = 0; k < 8; k++) data_b[k*8 +: 8] = byte_b(k);
        {sel_a, mode_a, iv_a, ordy_a, sclr_a, eclr_a} = '0;
        {sel_b, iv_b, ordy_b} = '0;

        //          iv sel md ordy eclr sclr | er ev data es ee
        tbl[0]  = mk(1, 1, 0, 1, 0, 0, 1, 1, B, 1, 0);
        tbl[1]  = mk(1, 2, 0, 1, 0, 0, 1, 1, C, 2, 0);
        tbl[2]  = mk(0, 2, 0, 1, 0, 0, 1, 0, C, 2, 0);
        tbl[3]  = mk(1, 5, 0, 1, 0, 0, 1, 1, A, 0, 1);
        tbl[4]  = mk(1, 1, 0, 1, 0, 0, 1, 1, B, 1, 1);
        tbl[5]  = mk(0, 1, 0, 1, 1, 0, 1, 0, B, 1, 0);
        tbl[6]  = mk(1, 6, 0, 1, 0, 0, 1, 1, A, 0, 1);
        tbl[7]  = mk(1, 7, 0, 1, 1, 0, 1, 1, A, 0, 1);
        tbl[8]  = mk(0, 0, 0, 1, 1, 0, 1, 0, A, 0, 0);
        tbl[9]  = mk(1, 1, 0, 0, 0, 0, 1, 1, B, 1, 0);
        tbl[10] = mk(1, 2, 0, 0, 0, 0, 0, 1, B, 1, 0);
        tbl[11] = mk(0, 4, 1, 0, 0, 0, 0, 1, B, 1, 0);
        tbl[12] = mk(1, 2, 0, 1, 0, 0, 1, 1, C, 2, 0);
        tbl[13] = mk(0, 2, 0, 1, 0, 0, 1, 0, C, 2, 0);
        tbl[14] = mk(1, 5, 1, 1, 0, 0, 1, 1, A, 0, 0);
        tbl[15] = mk(1, 5, 1, 1, 0, 0, 1, 1, B, 1, 0);
        tbl[16] = mk(1, 5, 1, 1, 0, 0, 1, 1, C, 2, 0);
        tbl[17] = mk(1, 5, 1, 1, 0, 0, 1, 1, A, 0, 0);
        tbl[18] = mk(1, 5, 1, 1, 0, 0, 1, 1, B, 1, 0);
        tbl[19] = mk(1, 5, 1, 1, 0, 1, 1, 1, C, 2, 0);
        tbl[20] = mk(1, 5, 1, 1, 0, 0, 1, 1, A, 0, 0);
        tbl[21] = mk(0, 0, 0, 1, 0, 1, 1, 0, A, 0, 0);

        rst_seq[0] = mk(1, 0, 1, 1, 0, 0, 1, 1, A, 0, 0);
        rst_seq[1] = mk(1, 0, 1, 1, 0, 0, 1, 1, B, 1, 0);
        rst_seq[2] = mk(1, 3, 0, 1, 0, 0, 1, 1, A, 0, 1);

        @(posedge clk);
        #1;
        check("reset.data_out",  64'(dout_a), 64'h0);
        check("reset.out_valid", 64'(ov_a), 64'h0);
        check("reset.out_sel",   64'(osel_a), 64'h0);
        check("reset.sel_err",   64'(err_a), 64'h0);
        check("reset.in_ready",  64'(ir_a), 64'h1);
        check("reset.b_valid",   64'(ov_b), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 22; i++) apply_vec(tbl[i], $sformatf("vec%0d", i));

        // Load out_valid=1, sel_err=1, counter=2, then reset between edges.
        for (int i = 0; i < 3; i++) apply_vec(rst_seq[i], $sformatf("pre_rst%0d", i));
        iv_a   = 1'b0;
        ordy_a = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst.data_out",  64'(dout_a), 64'h0);
        check("async_rst.out_valid", 64'(ov_a), 64'h0);
        check("async_rst.out_sel",   64'(osel_a), 64'h0);
        check("async_rst.sel_err",   64'(err_a), 64'h0);
        check("async_rst.in_ready",  64'(ir_a), 64'h1);
        @(negedge clk);
        rst = 1'b0;
        apply_vec(mk(1, 4, 1, 1, 0, 0, 1, 1, A, 0, 0), "post_rst_scan");
        iv_a = 1'b0;

        // Scoreboard sweep on the 8-wide instance with random backpressure.
        next_sel = 0;
        cyc      = 0;
        while ((next_sel < 8 || q.size() != 0) && cyc < 300) begin
            iv_b   = (next_sel < 8) && ($urandom_range(0, 3) != 0);
            sel_b  = 3'(next_sel);
            ordy_b = ($urandom_range(0, 2) != 0);
            #1;
            rdy_m = (q.size() == 0) || ordy_b;
            check("sweep.in_ready",  64'(ir_b), 64'(rdy_m));
            check("sweep.out_valid", 64'(ov_b), 64'(q.size() != 0));
            if (q.size() != 0) begin
                check($sformatf("sweep.data_out[%0d]", q[0].s), 64'(dout_b), 64'(q[0].d));
                check($sformatf("sweep.out_sel[%0d]", q[0].s),  64'(osel_b), 64'(q[0].s));
                if (ordy_b) void'(q.pop_front());
            end
            if (iv_b && rdy_m) begin
                q.push_back('{byte_b(next_sel), 3'(next_sel)});
                next_sel++;
            end
            @(posedge clk);
            #1;
            check("sweep.sel_err", 64'(err_b), 64'h0);
            cyc++;
        end
        n_checks++;
        if (cyc >= 300) begin
            n_fail++;
            $display("FAIL sweep.timeout: got %0d selects with %0d pending expected 8 with 0 pending",
                     next_sel, q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected completion before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mux_n_reg
`default_nettype wire

// File: doc/mux_n_reg.md
Name: mux_n_reg

Overview:
- Parametrised, registered N-way datapath multiplexer for the multicycle CPU datapath.
- Generalises the fixed 3-input/3-bit-select mux in width, input count and default index.
- Adds a one-entry output register with valid/ready handshake, an auto-scan mode driven by an internal index counter, and a sticky out-of-range-select error flag.
- Sits between register-file/ALU sources and consumers that need a registered, flow-controlled source select.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- N_IN, 3, number of data inputs (2..2^SEL_W).
- SEL_W, 3, selector width; 2^SEL_W >= N_IN.
- DEFAULT_IDX, 0, index used for an out-of-range select (must be < N_IN).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  N_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- selector  input  SEL_W  input index used in direct mode.
- mode  input  1  0 = direct (use selector), 1 = scan (use internal counter).
- in_valid  input  1  request to capture a selection this cycle.
- in_ready  output  1  block can accept a capture this cycle.
- out_ready  input  1  downstream consumes data_out this cycle.
- scan_clr  input  1  synchronous clear of the scan counter.
- err_clr  input  1  synchronous clear of sel_err.
- data_out  output  WIDTH  registered selected data.
- out_valid  output  1  data_out holds an unconsumed value.
- out_sel  output  SEL_W  index actually used for the current data_out.
- sel_err  output  1  sticky flag: an out-of-range select occurred in direct mode.

Behaviour:
- Reset (async, immediate): data_out=0, out_valid=0, out_sel=0, sel_err=0, scan counter=0.
- in_ready = !out_valid || out_ready. This path is combinational, with no dependency on in_valid.
- Capture occurs when in_valid && in_ready. At that clock edge data_out, out_sel and out_valid=1 load together. Latency is one cycle from capture to out_valid.
- No capture and out_ready && out_valid: out_valid goes to 0 next edge. data_out and out_sel hold their last values.
- No capture and !out_ready: all outputs hold. data_out never changes while out_valid=1 && !out_ready.
- Simultaneous consume and capture in the same cycle: new data loads and out_valid stays 1. This gives full throughput of one transfer per cycle.
- Index resolution, sampled only at the capture edge:
  - mode=0 and selector < N_IN: idx = selector.
  - mode=0 and selector >= N_IN: idx = DEFAULT_IDX and sel_err is set.
  - mode=1: idx = scan counter. selector is ignored and never sets sel_err.
- Scan counter, SEL_W bits, values 0..N_IN-1:
  - Increments on every capture with mode=1.
  - Wraps from N_IN-1 to 0.
  - Holds otherwise.
  - scan_clr forces 0 and has priority over increment. A capture in the same cycle as scan_clr still uses the pre-clear value; the counter becomes 0, not 1.
- sel_err: if set and err_clr occur in the same cycle, set wins and the flag stays 1. Otherwise err_clr clears it.
- mode, selector and data_in changes outside a capture cycle have no effect.
- A reset asserted mid-transfer drops out_valid immediately and discards the pending data.

Decomposition:
- Shared package mux_pkg:
  - MODE_DIRECT=1'b0, MODE_SCAN=1'b1.
  - Default WIDTH=32.
- Sub-module mux_scan_ctr (parameters N_IN, SEL_W):
  - Ports: clk, reset, inc, clr, count.
  - Implements the wrap and clear-priority rules.
- The top level contains index resolution, the output register and the handshake.

Test Plan:
- Direct selects, WIDTH=32, N_IN=3, data_in={32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000}, out_ready=1. Pulse in_valid with selector=1, then 2 -> data_out 32'hBBBB0001 then 32'hCCCC0002 one cycle after each capture; out_sel=1, then 2; sel_err=0.
- Out of range: selector=3'b101, in_valid=1 -> data_out=32'hAAAA0000, out_sel=0, sel_err=1. Set sticks through later valid selects. err_clr=1 alone clears it. err_clr together with another bad select keeps sel_err=1.
- Backpressure: capture sel=1 with out_ready=0 -> out_valid=1, in_ready=0. A second in_valid with sel=2 is ignored and data_out stays 32'hBBBB0001. Raise out_ready -> second capture accepted in the same cycle; data_out becomes 32'hCCCC0002 with out_valid continuous.
- Scan mode: mode=1, 5 back-to-back captures -> out_sel sequence 0,1,2,0,1. Then scan_clr with a capture -> that capture uses 2 and the next capture uses 0.
- Reset mid-operation: assert reset asynchronously between edges while out_valid=1, sel_err=1 and counter=2 -> all outputs 0 immediately. After release, first scan capture uses index 0.
- Width/depth sweep: WIDTH=8, N_IN=8, SEL_W=3, all selects 0..7 -> the correct byte on each; sel_err never set.
